// File: rtl/pbch_dmrs_extractor_if.sv
// PBCH DMRS extractor bus bundle: SSB control, index-stream request,
// grid RAM read port and extracted DMRS output stream.
interface pbch_dmrs_extractor_if #(
  parameter int DATA_W = 16
);
  logic                start;
  logic                sym_req_valid;
  logic [1:0]          sym_req;
  logic [9:0]          index;
  logic                index_valid;
  logic                rd_en;
  logic [9:0]          rd_addr;
  logic [2*DATA_W-1:0] rd_data;
  logic                dmrs_valid;
  logic [2*DATA_W-1:0] dmrs_data;
  logic [7:0]          dmrs_cnt;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, index, index_valid, rd_data,
    output sym_req_valid, sym_req, rd_en, rd_addr,
    output dmrs_valid, dmrs_data, dmrs_cnt,
    output busy, done, err
  );

  modport slave (
    output start, index, index_valid, rd_data,
    input  sym_req_valid, sym_req, rd_en, rd_addr,
    input  dmrs_valid, dmrs_data, dmrs_cnt,
    input  busy, done, err
  );
endinterface

// File: rtl/pbch_dmrs_extractor.sv
// PBCH DMRS extractor: requests index streams for PBCH symbols 1..3,
// reads the grid RAM at each index and emits the 144 DMRS REs of an SSB.
module pbch_dmrs_extractor #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pbch_dmrs_extractor_if.master bus
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_COLLECT,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          code_q, code_d;
  logic                req_q, req_d;
  logic [TW-1:0]       wait_q, wait_d;
  logic [7:0]          sym_q, sym_d;
  logic [7:0]          tot_q, tot_d;
  logic                pend_q, pend_d;
  logic                dv_q, dv_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_en;
  logic [7:0]          exp_len;

  assign rd_en = !rst && bus.index_valid &&
                 (state_q == S_WAIT || state_q == S_COLLECT);
  assign exp_len = (code_q == 2'd2) ? 8'd24 : 8'd60;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    req_d   = 1'b0;
    wait_d  = wait_q;
    sym_d   = sym_q;
    tot_d   = tot_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    pend_d  = rd_en;
    dv_d    = pend_q;

    if (rd_en && sym_q != 8'hff)
      sym_d = sym_q + 8'd1;

    // read return: number it, saturating at the last RE of the SSB
    if (pend_q) begin
      data_d = bus.rd_data;
      cnt_d  = (tot_q > 8'd143) ? 8'd143 : tot_q;
      if (tot_q == 8'd144)
        err_d = 1'b1;
      else
        tot_d = tot_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_REQ;
          code_d  = 2'd1;
          req_d   = 1'b1;
          err_d   = 1'b0;
          tot_d   = 8'd0;
          cnt_d   = 8'd0;
          sym_d   = 8'd0;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        wait_d  = '0;
        sym_d   = 8'd0;
      end
      S_WAIT: begin
        if (bus.index_valid) begin
          state_d = S_COLLECT;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_COLLECT: begin
        if (!bus.index_valid)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (sym_q != exp_len)
          err_d = 1'b1;
        if (code_q == 2'd3) begin
          state_d = S_FIN;
        end else begin
          code_d  = code_q + 2'd1;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= 2'd0;
      req_q   <= 1'b0;
      wait_q  <= '0;
      sym_q   <= 8'd0;
      tot_q   <= 8'd0;
      pend_q  <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      req_q   <= req_d;
      wait_q  <= wait_d;
      sym_q   <= sym_d;
      tot_q   <= tot_d;
      pend_q  <= pend_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.sym_req_valid = req_q;
  assign bus.sym_req       = code_q;
  assign bus.rd_en         = rd_en;
  assign bus.rd_addr       = rd_en ? bus.index : 10'd0;
  assign bus.dmrs_valid    = dv_q;
  assign bus.dmrs_data     = data_q;
  assign bus.dmrs_cnt      = cnt_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
endmodule
